// File: rtl/alu_srl_sched_pkg.sv
// Shared types and defaults for the two-requester logical-right-shift scheduler.
package alu_srl_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_N  = 32;
    localparam int DEF_SW = 6;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/alu_srl.sv
// Combinational logical right shift; amounts at or beyond N shift everything out.
module alu_srl #(
    parameter int N  = 32,
    parameter int SW = 6
) (
    input  logic [N-1:0]  A,
    input  logic [SW-1:0] S,
    output logic [N-1:0]  Z
);

    assign Z = A >> S;

endmodule

// File: rtl/alu_srl_sched.sv
// Round-robin scheduler sharing one alu_srl between two requesters, one op in flight.
// Optional grant statistics counters are built when ALU_SRL_SCHED_STATS_EN is defined.
import alu_srl_sched_pkg::*;

module alu_srl_sched #(
    parameter int N  = DEF_N,
    parameter int SW = DEF_SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [N-1:0]  req0_a,
    input  logic [SW-1:0] req0_s,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [N-1:0]  req1_a,
    input  logic [SW-1:0] req1_s,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [N-1:0]  rsp_z
`ifdef ALU_SRL_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    state_t        state_q, state_d;
    logic          prio_q;
    logic [N-1:0]  a_q;
    logic [SW-1:0] s_q;
    logic          id_q;
    logic          rsp_valid_q;
    logic [N-1:0]  rsp_z_q;
    logic          grant;
    logic          gnt_id;
    logic [N-1:0]  alu_z;

    // prio_q names the requester that wins a tie; it flips away from whoever was just granted.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        gnt_id  = prio_q;
        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant  = 1'b1;
                    gnt_id = prio_q;
                end else if (req0_valid) begin
                    grant  = 1'b1;
                    gnt_id = 1'b0;
                end else if (req1_valid) begin
                    grant  = 1'b1;
                    gnt_id = 1'b1;
                end
                if (grant) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready = rst_n && grant && !gnt_id;
    assign req1_ready = rst_n && grant && gnt_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            a_q         <= '0;
            s_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                prio_q <= ~gnt_id;
                a_q    <= gnt_id ? req1_a : req0_a;
                s_q    <= gnt_id ? req1_s : req0_s;
                id_q   <= gnt_id;
            end
            if (state_q == EXEC) begin
                rsp_z_q     <= alu_z;
                rsp_valid_q <= 1'b1;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    alu_srl #(.N(N), .SW(SW)) u_alu_srl (
        .A (a_q),
        .S (s_q),
        .Z (alu_z)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_z     = rsp_z_q;

`ifdef ALU_SRL_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Counters saturate rather than wrap so a long run never reports a misleadingly small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (grant) begin
            if (!gnt_id && cnt0_q != '1) begin
                cnt0_q <= cnt0_q + 1'b1;
            end
            if (gnt_id && cnt1_q != '1) begin
                cnt1_q <= cnt1_q + 1'b1;
            end
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`else
    // Statistics build disabled: no counter state exists.
`endif

endmodule

// File: tb/tb_alu_srl_sched.sv
// Directed bench for alu_srl_sched: latency, round-robin, shift boundaries, back-pressure, reset.
module tb_alu_srl_sched;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req1_a;
    logic [5:0]  req0_s, req1_s;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_z;
`ifdef ALU_SRL_SCHED_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    int passCount  = 0;
    int totalCount = 0;

    alu_srl_sched #(.N(32), .SW(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_s     (req0_s),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_s     (req1_s),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_z      (rsp_z)
`ifdef ALU_SRL_SCHED_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [5:0] s0,
                                 input logic v1, input logic [31:0] a1, input logic [5:0] s1,
                                 input logic rr);
        req0_valid = v0; req0_a = a0; req0_s = s0;
        req1_valid = v1; req1_a = a1; req1_s = s1;
        rsp_ready  = rr;
    endtask

    // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One complete single-requester operation with rsp_ready held high.
    task automatic doOp(input logic id, input logic [31:0] a, input logic [5:0] s,
                        input logic [31:0] expZ, input string tag);
        if (id) applyStimulus(1'b0, '0, '0, 1'b1, a, s, 1'b1);
        else    applyStimulus(1'b1, a, s, 1'b0, '0, '0, 1'b1);
        #1;
        checkOutput({tag, " ready0"}, {31'd0, req0_ready}, {31'd0, !id});
        checkOutput({tag, " ready1"}, {31'd0, req1_ready}, {31'd0, id});
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        #1;
        checkOutput({tag, " exec valid"}, {31'd0, rsp_valid}, 32'd0);
        tick();
        #1;
        checkOutput({tag, " rsp valid"}, {31'd0, rsp_valid}, 32'd1);
        checkOutput({tag, " rsp z"}, rsp_z, expZ);
        checkOutput({tag, " rsp id"}, {31'd0, rsp_id}, {31'd0, id});
        tick();
    endtask

    initial begin
        // Reset state, with a pending valid to confirm ready stays low.
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'hDEADBEEF, 6'd3, 1'b1, 32'h1, 6'd1, 1'b0);
        #12;
        checkOutput("reset ready0", {31'd0, req0_ready}, 32'd0);
        checkOutput("reset ready1", {31'd0, req1_ready}, 32'd0);
        checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_id", {31'd0, rsp_id}, 32'd0);
        checkOutput("reset rsp_z", rsp_z, 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Latency: grant in cycle t, response visible in t+2.
        doOp(1'b0, 32'h80000000, 6'd31, 32'h00000001, "lat");
        #1;
        checkOutput("lat done valid", {31'd0, rsp_valid}, 32'd0);

        // Fresh reset, then both requesters continuously valid: grants alternate from 0.
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'hFFFFFFFF, 6'd4, 1'b1, 32'h0000F000, 6'd12, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("rr%0d ready0", i), {31'd0, req0_ready}, {31'd0, (i % 2) == 0});
            checkOutput($sformatf("rr%0d ready1", i), {31'd0, req1_ready}, {31'd0, (i % 2) == 1});
            tick();
            tick();
            #1;
            checkOutput($sformatf("rr%0d valid", i), {31'd0, rsp_valid}, 32'd1);
            checkOutput($sformatf("rr%0d z", i), rsp_z, (i % 2) == 0 ? 32'h0FFFFFFF : 32'h0000000F);
            checkOutput($sformatf("rr%0d id", i), {31'd0, rsp_id}, {31'd0, (i % 2) == 1});
            checkOutput($sformatf("rr%0d resp ready0", i), {31'd0, req0_ready}, 32'd0);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);

        // Shift boundaries on requester 1 (pointer favours 0, single valid still wins).
        doOp(1'b1, 32'h12345678, 6'd32, 32'h00000000, "s32");
        doOp(1'b1, 32'h12345678, 6'd63, 32'h00000000, "s63");
        doOp(1'b1, 32'h12345678, 6'd0,  32'h12345678, "s0");
        doOp(1'b1, 32'h12345678, 6'd4,  32'h01234567, "s4");

        // Back-pressure: result held for 5 cycles with both requesters waiting.
        applyStimulus(1'b1, 32'h0000FFFF, 6'd8, 1'b0, '0, '0, 1'b0);
        #1;
        checkOutput("bp grant0", {31'd0, req0_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hAAAAAAAA, 6'd1, 1'b1, 32'h00000100, 6'd8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("bp%0d valid", i), {31'd0, rsp_valid}, 32'd1);
            checkOutput($sformatf("bp%0d z", i), rsp_z, 32'h000000FF);
            checkOutput($sformatf("bp%0d id", i), {31'd0, rsp_id}, 32'd0);
            checkOutput($sformatf("bp%0d readys", i), {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp release readys", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();
        #1;
        checkOutput("bp after valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("bp next ready1", {31'd0, req1_ready}, 32'd1);
        checkOutput("bp next ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        tick();
        #1;
        checkOutput("bp2 z", rsp_z, 32'h00000001);
        checkOutput("bp2 id", {31'd0, rsp_id}, 32'd1);
        tick();

        // Reset during EXEC discards the op and restores the pointer to requester 0.
        doOp(1'b0, 32'h000000F0, 6'd4, 32'h0000000F, "pre");
        applyStimulus(1'b1, 32'hFFFF0000, 6'd16, 1'b0, '0, '0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'hFFFF0000, 6'd16, 1'b0, '0, '0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst exec ready0", {31'd0, req0_ready}, 32'd0);
        checkOutput("rst exec valid", {31'd0, rsp_valid}, 32'd0);
        req0_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            checkOutput($sformatf("rst drop valid%0d", i), {31'd0, rsp_valid}, 32'd0);
        end
        applyStimulus(1'b1, 32'h00000010, 6'd4, 1'b1, 32'h00000020, 6'd4, 1'b1);
        #1;
        checkOutput("rst tie ready0", {31'd0, req0_ready}, 32'd1);
        checkOutput("rst tie ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        tick();
        #1;
        checkOutput("rst tie z", rsp_z, 32'h00000001);
        tick();

`ifdef ALU_SRL_SCHED_STATS_EN
        // Grant counters: 3 to requester 0 and 2 to requester 1 after a fresh reset.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        doOp(1'b0, 32'h8, 6'd3, 32'h1, "c0a");
        doOp(1'b1, 32'h8, 6'd2, 32'h2, "c1a");
        doOp(1'b0, 32'h8, 6'd1, 32'h4, "c0b");
        doOp(1'b1, 32'h8, 6'd0, 32'h8, "c1b");
        doOp(1'b0, 32'h8, 6'd4, 32'h0, "c0c");
        #1;
        checkOutput("gnt_cnt0", {16'd0, gnt_cnt0}, 32'd3);
        checkOutput("gnt_cnt1", {16'd0, gnt_cnt1}, 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("gnt_cnt0 reset", {16'd0, gnt_cnt0}, 32'd0);
        checkOutput("gnt_cnt1 reset", {16'd0, gnt_cnt1}, 32'd0);
        rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
